// File: rtl/adder_sched_pkg.sv
// Shared types and sizing helpers for the round-robin adder scheduler.
package adder_sched_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StHalt  = 2'd2
    } sched_state_e;

    function automatic int unsigned id_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Response entry is packed as {id, sum, carry}, carry in bit 0.
    function automatic int unsigned entry_w(input int unsigned idw, input int unsigned width);
        return idw + width + 1;
    endfunction

endpackage

// File: rtl/adder_sched_fifo.sv
// Synchronous FIFO holding adder responses; exposes occupancy for credit accounting.
module adder_sched_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined adder; responses return in issue order.
// Optional ADDER_SCHED_STATS_EN adds saturating stat_issued / stat_stall counters.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADD_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ID_W      = id_w(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         add_in_1,
    output logic [WIDTH-1:0]         add_in_2,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    input  logic                     drain_req,
`ifdef ADDER_SCHED_STATS_EN
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_stall,
`endif
    output logic                     drain_done
);

    localparam int unsigned ENTRY_W = entry_w(ID_W, WIDTH);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be within 2..8");
    end
    if (ADD_LAT < 1) begin : g_bad_add_lat
        $error("ADD_LAT must be at least 1");
    end
    if (FIFO_DEPTH < ADD_LAT + 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be >= ADD_LAT+2");
    end

    sched_state_e                  state_q, state_d;
    logic [ID_W-1:0]               ptr_q, ptr_d;
    logic [WIDTH-1:0]              in_1_q, in_1_d, in_2_q, in_2_d;
    logic                          launch_v_q, launch_v_d;
    logic [ID_W-1:0]               launch_id_q, launch_id_d;
    logic [ADD_LAT-1:0]            tag_v_q, tag_v_d;
    logic [ADD_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

    logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]            fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]              fifo_count;

    int unsigned                   inflight;
    int unsigned                   arb_idx;
    logic                          credit_ok, grant_en, hs;
    logic [ID_W-1:0]               grant_id;

    always_comb begin
        inflight = 32'(launch_v_q);
        for (int unsigned i = 0; i < ADD_LAT; i++) begin
            inflight = inflight + 32'(tag_v_q[i]);
        end
        // Entries popping this cycle still hold their credit.
        credit_ok = !fifo_full && ((inflight + 32'(fifo_count)) < FIFO_DEPTH);
        grant_en  = reset_n && (state_q == StRun) && !drain_req && credit_ok;

        req_ready = '0;
        hs        = 1'b0;
        grant_id  = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!hs && grant_en && req_valid[arb_idx]) begin
                hs       = 1'b1;
                grant_id = ID_W'(arb_idx);
            end
        end
        if (hs) begin
            req_ready[grant_id] = 1'b1;
        end

        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end

        launch_v_d  = hs;
        launch_id_d = hs ? grant_id : launch_id_q;
        in_1_d      = hs ? req_a[32'(grant_id)*WIDTH +: WIDTH] : in_1_q;
        in_2_d      = hs ? req_b[32'(grant_id)*WIDTH +: WIDTH] : in_2_q;

        // Tag stages ride alongside the adder pipeline.
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        tag_v_d[0]  = launch_v_q;
        tag_id_d[0] = launch_id_q;
        for (int unsigned i = 1; i < ADD_LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end

        fifo_push  = tag_v_q[ADD_LAT-1];
        fifo_wdata = {tag_id_q[ADD_LAT-1], add_sum, add_carry};
        fifo_pop   = rsp_valid && rsp_ready;

        state_d = state_q;
        unique case (state_q)
            StRun:   if (drain_req) state_d = StDrain;
            StDrain: if (inflight == 0 && fifo_empty) state_d = StHalt;
            StHalt:  if (!drain_req) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRun;
            ptr_q       <= '0;
            in_1_q      <= '0;
            in_2_q      <= '0;
            launch_v_q  <= 1'b0;
            launch_id_q <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            in_1_q      <= in_1_d;
            in_2_q      <= in_2_d;
            launch_v_q  <= launch_v_d;
            launch_id_q <= launch_id_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
        end
    end

    adder_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign add_in_1   = in_1_q;
    assign add_in_2   = in_2_q;
    assign rsp_valid  = !fifo_empty;
    assign {rsp_id, rsp_sum, rsp_carry} = fifo_empty ? '0 : fifo_rdata;
    assign drain_done = (state_q == StHalt);

`ifdef ADDER_SCHED_STATS_EN
    logic [15:0] issued_q, issued_d, stall_q, stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (hs && issued_q != 16'hFFFF) begin
            issued_d = issued_q + 16'd1;
        end
        if (|req_valid && state_q == StRun && !credit_ok && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`endif

endmodule
